// File: rtl/mips32_pkg.sv
// Shared fetch-path definitions: FSM states, instruction width and the
// default reset PC used by the instruction fetch unit.
package mips32_pkg;

  localparam int INST_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifuState_e;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch buffer for the fetch unit: DEPTH entries (power of two), with
// simultaneous push/pop allowed when full and a flush that empties it at once.
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             almostFull,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] memArray [DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [CNT_W-1:0] countReg;
  logic             doPush;
  logic             doPop;

  assign empty      = (countReg == '0);
  assign full       = (countReg == FULL_CNT);
  assign almostFull = (countReg == FULL_CNT - CNT_W'(1));

  // A pop frees the slot the same-cycle push lands in, so full never blocks it.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  always_ff @(posedge clk) begin
    if (doPush && !flush) begin
      memArray[wrPtrReg] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else if (flush) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + PTR_W'(1);
      if (doPop)  rdPtrReg <= rdPtrReg + PTR_W'(1);
      countReg <= countReg + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  assign headData = memArray[rdPtrReg];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetch FSM feeding a prefetch
// buffer toward decode. Define IFU_PERF_CNT_EN to add the fetch_cnt output.
module inst_fetch_unit
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [7:0]        imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt
`endif
);

  ifuState_e            stateReg;
  ifuState_e            stateNext;
  logic [31:0]          fetchPcReg;
  logic [31:0]          fetchPcNext;
  logic [7:0]           addrReg;
  logic                 fifoFull;
  logic                 fifoAlmostFull;
  logic                 fifoEmpty;
  logic                 pushEn;
  logic                 popEn;
  logic                 roomAfterPush;
  logic [INST_W+31:0]   headData;

  assign popEn  = inst_valid && inst_ready;
  // Redirect wins over a same-cycle ack: that word belongs to the old path.
  assign pushEn = (stateReg == WAIT) && imem_ack && !redirect;
  assign roomAfterPush = popEn ? !fifoFull : (!fifoFull && !fifoAlmostFull);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateReg <= IDLE;
    else      stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (!redirect && !fifoFull) stateNext = WAIT;
      WAIT: begin
        if (redirect)      stateNext = imem_ack ? IDLE : DROP;
        else if (imem_ack) stateNext = roomAfterPush ? WAIT : IDLE;
      end
      DROP:    if (imem_ack) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (stateReg != IDLE);
    imem_addr = addrReg;
  end

  always_comb begin
    fetchPcNext = fetchPcReg;
    if (redirect)    fetchPcNext = {redirect_pc[31:2], 2'b00};
    else if (pushEn) fetchPcNext = fetchPcReg + 32'd4;
  end

  // While draining a stale response the address must stay on the old request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPcReg <= RESET_PC;
      addrReg    <= RESET_PC[9:2];
    end else begin
      fetchPcReg <= fetchPcNext;
      addrReg    <= (stateNext == DROP) ? addrReg : fetchPcNext[9:2];
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W + 32)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (pushEn),
    .pushData   ({imem_rdata, fetchPcReg}),
    .pop        (popEn),
    .flush      (redirect),
    .headData   (headData),
    .full       (fifoFull),
    .almostFull (fifoAlmostFull),
    .empty      (fifoEmpty)
  );

  assign inst_valid = !fifoEmpty;
  assign inst       = inst_valid ? headData[INST_W+31:32] : '0;
  assign inst_pc    = inst_valid ? headData[31:0] : '0;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetchCntReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       fetchCntReg <= '0;
    else if (popEn) fetchCntReg <= fetchCntReg + 32'd1;
  end

  assign fetch_cnt = fetchCntReg;
`endif

endmodule
